// File: rtl/latch_pkg.sv
// rtl/latch_pkg.sv - shared types and constants for the latch edge counter
package latch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int SYNC_MIN = 2;
    localparam int SYNC_MAX = 4;

    function automatic bit in_range(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-flop synchroniser for one asynchronous level
module sync_chain #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] r_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh <= '0;
        end else begin
            r_sh <= {r_sh[DEPTH-2:0], d};
        end
    end

    assign q = r_sh[DEPTH-1];

endmodule

// File: rtl/latch_edge_counter.sv
// rtl/latch_edge_counter.sv - synchronise latch Q, count rising edges, hand off read-and-clear snapshots
module latch_edge_counter
    import latch_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             q_in,
    input  logic             en,
    input  logic             snap,
    input  logic             snap_ready,
    output logic             q_sync,
    output logic             rise,
    output logic             fall,
    output logic [WIDTH-1:0] count,
    output logic             sat,
    output logic [WIDTH-1:0] snap_data,
    output logic             snap_valid
);

    // An out-of-range depth falls back to the minimum safe synchroniser.
    localparam int SYNC_D = in_range(SYNC_STAGES, SYNC_MIN, SYNC_MAX) ? SYNC_STAGES : SYNC_MIN;
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_snap_data;
    logic             r_sat;
    logic             r_snap_valid;
    logic             r_prev;

    logic             w_q_sync;
    logic             w_rise;
    logic             w_counting;
    logic             w_inc;
    logic             w_at_max;
    logic             w_capture;
    logic [WIDTH-1:0] w_snap_val;

    sync_chain #(
        .DEPTH(SYNC_D)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (q_in),
        .q  (w_q_sync)
    );

    assign w_rise     = w_q_sync & ~r_prev;
    assign w_counting = en & (r_state != IDLE);
    assign w_inc      = w_counting & w_rise;
    assign w_at_max   = (r_count == CNT_MAX);
    assign w_capture  = snap & (r_state != REPORT);
    // A rise in the capture cycle belongs to the snapshot, not the cleared counter.
    assign w_snap_val = (w_inc && !w_at_max) ? r_count + 1'b1 : r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_snap_data  <= '0;
            r_sat        <= 1'b0;
            r_snap_valid <= 1'b0;
            r_prev       <= 1'b0;
        end else begin
            r_prev <= w_q_sync;
            if (w_capture) begin
                r_snap_data  <= w_snap_val;
                r_snap_valid <= 1'b1;
                r_count      <= '0;
                r_sat        <= 1'b0;
                r_state      <= REPORT;
            end else begin
                if (w_inc) begin
                    if (w_at_max) begin
                        r_sat <= 1'b1;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                case (r_state)
                    IDLE: begin
                        if (en) r_state <= COUNT;
                    end
                    COUNT: begin
                        if (!en) r_state <= IDLE;
                    end
                    REPORT: begin
                        if (r_snap_valid && snap_ready) begin
                            r_snap_valid <= 1'b0;
                            r_state      <= en ? COUNT : IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign q_sync     = w_q_sync;
    assign rise       = w_rise;
    assign fall       = ~w_q_sync & r_prev;
    assign count      = r_count;
    assign sat        = r_sat;
    assign snap_data  = r_snap_data;
    assign snap_valid = r_snap_valid;

endmodule

// File: tb/tb_latch_edge_counter.sv
// tb/tb_latch_edge_counter.sv - randomized and directed bench against a behavioural model
module tb_latch_edge_counter;

    localparam int W    = 3;
    localparam int S    = 2;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst, q_in, en, snap, snap_ready;
    logic         q_sync, rise, fall, sat, snap_valid;
    logic [W-1:0] count, snap_data;

    latch_edge_counter #(
        .WIDTH(W),
        .SYNC_STAGES(S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .q_in      (q_in),
        .en        (en),
        .snap      (snap),
        .snap_ready(snap_ready),
        .q_sync    (q_sync),
        .rise      (rise),
        .fall      (fall),
        .count     (count),
        .sat       (sat),
        .snap_data (snap_data),
        .snap_valid(snap_valid)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int n_rise  = 0;
    int n_fall  = 0;

    // model: q_in samples newest-first, mode 0=idle 1=count 2=report
    bit m_samp[$];
    int m_cnt, m_data, m_mode;
    bit m_sat, m_valid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_step(input bit r, input bit q, input bit e, input bit s, input bit rd);
        bit m_rise;
        bit counting;
        int tot;
        if (r) begin
            m_samp = {};
            repeat (S + 1) m_samp.push_back(1'b0);
            m_cnt = 0; m_sat = 0; m_data = 0; m_valid = 0; m_mode = 0;
        end else begin
            m_rise   = m_samp[S-1] & ~m_samp[S];
            counting = e && (m_mode != 0);
            if (s && m_mode != 2) begin
                tot     = m_cnt + ((counting && m_rise) ? 1 : 0);
                m_data  = (tot > MAXV) ? MAXV : tot;
                m_cnt   = 0;
                m_sat   = 0;
                m_valid = 1;
                m_mode  = 2;
            end else begin
                if (counting && m_rise) begin
                    if (m_cnt == MAXV) m_sat = 1;
                    else m_cnt++;
                end
                if (m_mode == 0 && e) m_mode = 1;
                else if (m_mode == 1 && !e) m_mode = 0;
                else if (m_mode == 2 && rd) begin
                    m_valid = 0;
                    m_mode  = e ? 1 : 0;
                end
            end
            m_samp.push_front(q);
            void'(m_samp.pop_back());
        end
    endtask

    task automatic cycle(input bit q, input bit e, input bit s, input bit rd, input bit r);
        @(negedge clk);
        chk("q_sync", q_sync, m_samp[S-1]);
        chk("rise", rise, m_samp[S-1] & ~m_samp[S]);
        chk("fall", fall, ~m_samp[S-1] & m_samp[S]);
        chk("count", count, m_cnt);
        chk("sat", sat, m_sat);
        chk("snap_valid", snap_valid, m_valid);
        chk("snap_data", snap_data, m_data);
        n_rise += int'(rise);
        n_fall += int'(fall);
        rst = r; q_in = q; en = e; snap = s; snap_ready = rd;
        m_step(r, q, e, s, rd);
    endtask

    task automatic pulses(input int n, input int hi, input int lo, input bit e);
        for (int i = 0; i < n; i++) begin
            repeat (hi) cycle(1'b1, e, 1'b0, 1'b0, 1'b0);
            repeat (lo) cycle(1'b0, e, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [W-1:0] held;
        bit           qr;
        rst = 1'b1; q_in = 1'b0; en = 1'b0; snap = 1'b0; snap_ready = 1'b0;
        m_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);

        // reset state
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // reset release with q_in high
        repeat (2) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        n_rise = 0;
        repeat (6) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_rel_rises", n_rise, 1);
        chk("rst_rel_count", count, 1);

        // five clean pulses, then snapshot
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_rise = 0; n_fall = 0;
        pulses(5, 4, 4, 1'b1);
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("edge_count", count, 5);
        chk("edge_rises", n_rise, 5);
        chk("edge_falls", n_fall, 5);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("edge_snap_data", snap_data, 5);
        chk("edge_snap_count", count, 0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // saturation
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        pulses(9, 4, 4, 1'b1);
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("sat_count", count, MAXV);
        chk("sat_flag", sat, 1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("sat_snap_data", snap_data, MAXV);
        chk("sat_cleared", sat, 0);
        chk("sat_count_clr", count, 0);

        // rise in the same cycle as snap
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        pulses(3, 4, 4, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("coin_snap_data", snap_data, 4);
        chk("coin_count", count, 0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // backpressure with repeated snap
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        pulses(1, 4, 4, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        held = snap_data;
        chk("bp_first_data", held, 1);
        for (int i = 0; i < 10; i++) begin
            cycle((i % 6) < 3, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        chk("bp_data_stable", snap_data, held);
        chk("bp_valid_held", snap_valid, 1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp_count_after", count, 2);
        chk("bp_valid_clr", snap_valid, 0);

        // disabled counting, then reset during REPORT
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        pulses(2, 4, 4, 1'b0);
        chk("dis_count", count, 0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_rep_valid", snap_valid, 0);
        chk("rst_rep_count", count, 0);

        // randomized traffic
        qr = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) qr = ~qr;
            cycle(qr, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 99) == 0);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
